mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the data and address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum ACCESS cycles allowed before an error.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 arst_n  in  1  asynchronous, active-low reset.
REQ-005 valid_i  in  1  the EX/MEM register holds a live instruction.
REQ-006 aluout_i  in  DATA_W  memory address from EX/MEM.
REQ-007 dreg2_i  in  DATA_W  store data from EX/MEM.
REQ-008 memread_i, memwrite_i, membranch_i, zero_i  in  1 each  control from EX/MEM.
REQ-009 branchpc_i  in  64  branch target from EX/MEM.
REQ-010 mem_req  out  1  data-memory request.
REQ-011 mem_we  out  1  write strobe; 1 = store.
REQ-012 mem_addr, mem_wdata  out  DATA_W each  address and store data.
REQ-013 mem_rdata  in  DATA_W  load data; valid when mem_ack=1.
REQ-014 mem_ack  in  1  one-cycle completion pulse from memory.
REQ-015 memreg_o  out  DATA_W  load result to the MEM/WB register.
REQ-016 pipe_en  out  1  enable for all pipeline registers; 0 = stall.
REQ-017 pcsrc_o  out  1  take-branch select to fetch.
REQ-018 branchpc_o  out  64  redirect target.
REQ-019 mem_err  out  1  sticky timeout flag.

Function
REQ-020 The block SHALL implement the FSM states IDLE, ACCESS, DONE and ERR.
REQ-021 A memory op SHALL be valid_i & (memread_i | memwrite_i); when both read and write are set, the write SHALL take priority.
REQ-022 IDLE, no memory op: pipe_en=1, mem_req=0, and the state SHALL remain IDLE.
REQ-023 IDLE, memory op: pipe_en=0 in the same cycle, and the next state SHALL be ACCESS.
REQ-024 In ACCESS the block SHALL drive mem_req=1, mem_we=memwrite_i, mem_addr=aluout_i, mem_wdata=dreg2_i and pipe_en=0; these inputs are stable because the pipeline is stalled.
REQ-025 Outside ACCESS the block SHALL drive mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-026 ACCESS with mem_ack=1: the next state SHALL be DONE, and for a read the block SHALL register mem_rdata into memreg_o on that edge.
REQ-027 A write SHALL leave memreg_o unchanged; memreg_o SHALL change only on a read acknowledge.
REQ-028 In DONE the block SHALL drive pipe_en=1 for exactly one cycle, launch no request, and go to IDLE next.
REQ-029 Latency: a non-memory instruction SHALL incur 0 stall cycles; a memory op acknowledged in its k-th ACCESS cycle (k ≥ 1) SHALL stall k+1 cycles and occupy the stage for k+2 cycles.
REQ-030 A 5-bit (or wider, ≥ clog2(TIMEOUT+1)) counter SHALL clear on ACCESS entry and increment on each ACCESS cycle without ack.
REQ-031 An ack in ACCESS cycle TIMEOUT SHALL be accepted; if there is no ack by that cycle, the next state SHALL be ERR.
REQ-032 ERR SHALL be absorbing until reset, with mem_err=1, pipe_en=0 and mem_req=0.
REQ-033 An mem_ack arriving in IDLE, DONE or ERR SHALL be ignored and SHALL NOT change memreg_o.
REQ-034 The block SHALL drive pcsrc_o = valid_i & membranch_i & zero_i & pipe_en, so a redirect coincides only with a pipeline advance.
REQ-035 The block SHALL drive branchpc_o = branchpc_i combinationally.
REQ-036 A branch-flagged memory op SHALL assert pcsrc_o only in its DONE cycle.

Reset
REQ-037 While arst_n=0 the block SHALL force state=IDLE, counter=0, memreg_o=0 and mem_err=0 immediately, without waiting for clk.
REQ-038 A reset asserted mid-ACCESS SHALL drop mem_req within the reset assertion, with no clock edge required.
REQ-039 After reset release the first rising edge SHALL evaluate from IDLE.
REQ-040 With state IDLE after reset and valid_i=0, outputs SHALL be pipe_en=1 and pcsrc_o=0.

Verification
REQ-041 ALU op (valid_i=1, memread_i=0, memwrite_i=0) for 3 cycles -> pipe_en=1 in every cycle, mem_req never asserted.
REQ-042 Load at addr 0x40, ack in 1st ACCESS cycle with rdata 0xDEADBEEF -> pipe_en=0 for 2 cycles, then pipe_en=1 for 1 cycle; memreg_o=0xDEADBEEF in the DONE cycle.
REQ-043 Store at addr 0x80 with data 0x1234, ack on 3rd ACCESS cycle -> mem_we=1, mem_addr=0x80, mem_wdata=0x1234 held for 3 cycles; 4 stall cycles; memreg_o unchanged.
REQ-044 Load with no ack (TIMEOUT=16) -> after 16 ACCESS cycles, mem_err=1 and pipe_en=0 permanently; a spurious ack afterwards is ignored; arst_n low clears mem_err.
REQ-045 Stray mem_ack in IDLE, plus a branch with membranch_i=1 and zero_i=1 -> memreg_o unchanged, pcsrc_o=1, branchpc_o=branchpc_i in the same cycle.
REQ-046 arst_n pulsed low in the 2nd ACCESS cycle -> mem_req=0 at once, state returns to IDLE, memreg_o=0.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port of the MEM stage: request/strobe/address/data out, load data and
// one-cycle completion pulse back.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: stalls the pipeline around a variable-latency data-memory
// access, captures load data, flags timeouts and gates branch redirects.
module mem_stage_ctrl #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              arst_n,

    input  logic              valid_i,
    input  logic [DATA_W-1:0] aluout_i,
    input  logic [DATA_W-1:0] dreg2_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              membranch_i,
    input  logic              zero_i,
    input  logic [63:0]       branchpc_i,

    mem_stage_ctrl_if.master  dmem,

    output logic [DATA_W-1:0] memreg_o,
    output logic              pipe_en,
    output logic              pcsrc_o,
    output logic [63:0]       branchpc_o,
    output logic              mem_err
);

    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW > 5) ? CNT_RAW : 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] memreg_q, memreg_d;
    logic              err_q, err_d;

    logic mem_op;
    logic is_load;

    assign mem_op  = valid_i & (memread_i | memwrite_i);
    // A store wins when both read and write are flagged, so only a pure read captures data.
    assign is_load = memread_i & ~memwrite_i;

    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        memreg_d = memreg_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (dmem.mem_ack) begin
                    state_d = S_DONE;
                    if (is_load) begin
                        memreg_d = dmem.mem_rdata;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            memreg_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            memreg_q <= memreg_d;
            err_q    <= err_d;
        end
    end

    // Bus outputs decode directly from the state flop, so an async reset drops mem_req at once.
    always_comb begin
        dmem.mem_req   = 1'b0;
        dmem.mem_we    = 1'b0;
        dmem.mem_addr  = '0;
        dmem.mem_wdata = '0;
        pipe_en        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pipe_en = ~mem_op;
            end
            S_ACCESS: begin
                dmem.mem_req   = 1'b1;
                dmem.mem_we    = memwrite_i;
                dmem.mem_addr  = aluout_i;
                dmem.mem_wdata = dreg2_i;
            end
            S_DONE: begin
                pipe_en = 1'b1;
            end
            S_ERR: begin
                pipe_en = 1'b0;
            end
            default: begin
                pipe_en = 1'b0;
            end
        endcase
    end

    // A redirect is only allowed when the pipeline actually advances.
    assign pcsrc_o    = valid_i & membranch_i & zero_i & pipe_en;
    assign branchpc_o = branchpc_i;
    assign memreg_o   = memreg_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl with a scoreboard of expected
// memreg_o values pushed at stimulus time and popped at each DONE cycle.
module tb_mem_stage_ctrl;

    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              valid_i;
    logic [DATA_W-1:0] aluout_i;
    logic [DATA_W-1:0] dreg2_i;
    logic              memread_i;
    logic              memwrite_i;
    logic              membranch_i;
    logic              zero_i;
    logic [63:0]       branchpc_i;
    logic [DATA_W-1:0] memreg_o;
    logic              pipe_en;
    logic              pcsrc_o;
    logic [63:0]       branchpc_o;
    logic              mem_err;

    mem_stage_ctrl_if #(.DATA_W(DATA_W)) dmem ();

    mem_stage_ctrl #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .valid_i    (valid_i),
        .aluout_i   (aluout_i),
        .dreg2_i    (dreg2_i),
        .memread_i  (memread_i),
        .memwrite_i (memwrite_i),
        .membranch_i(membranch_i),
        .zero_i     (zero_i),
        .branchpc_i (branchpc_i),
        .dmem       (dmem),
        .memreg_o   (memreg_o),
        .pipe_en    (pipe_en),
        .pcsrc_o    (pcsrc_o),
        .branchpc_o (branchpc_o),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_memreg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i          = 1'b0;
        memread_i        = 1'b0;
        memwrite_i       = 1'b0;
        membranch_i      = 1'b0;
        zero_i           = 1'b0;
        dmem.mem_ack     = 1'b0;
        dmem.mem_rdata   = '0;
    endtask

    // One memory op acknowledged in ACCESS cycle k; called right after a rising edge.
    task automatic do_op(input string tag, input logic rd, input logic wr, input logic br,
                         input logic zr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int k);
        int stalls = 0;
        bit done   = 1'b0;
        valid_i     = 1'b1;
        memread_i   = rd;
        memwrite_i  = wr;
        membranch_i = br;
        zero_i      = zr;
        aluout_i    = addr;
        dreg2_i     = wdata;
        if (!wr) model_memreg = rdata;
        exp_q.push_back(model_memreg);

        for (int c = 0; c < 40 && !done; c++) begin
            dmem.mem_ack   = (c == k);
            dmem.mem_rdata = (c == k) ? rdata : ~rdata;
            @(negedge clk);
            if (pipe_en === 1'b1) begin
                done = 1'b1;
            end else begin
                stalls++;
                check({tag, ":pcsrc_stall"}, pcsrc_o, 64'd0);
                if (c == 0) begin
                    check({tag, ":req_idle"}, dmem.mem_req, 64'd0);
                end else begin
                    check({tag, ":req"},   dmem.mem_req,   64'd1);
                    check({tag, ":we"},    dmem.mem_we,    {63'd0, wr});
                    check({tag, ":addr"},  dmem.mem_addr,  addr);
                    check({tag, ":wdata"}, dmem.mem_wdata, wr ? wdata : 64'd0);
                end
                tick();
            end
        end

        check({tag, ":done_seen"}, {63'd0, done}, 64'd1);
        check({tag, ":stalls"}, 64'(stalls), 64'(k + 1));
        check({tag, ":req_done"}, dmem.mem_req, 64'd0);
        check({tag, ":pcsrc_done"}, pcsrc_o, {63'd0, br & zr});
        if (exp_q.size() != 0) begin
            check({tag, ":memreg"}, memreg_o, exp_q.pop_front());
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n       = 1'b0;
        aluout_i     = '0;
        dreg2_i      = '0;
        branchpc_i   = 64'h0000_0000_0040_1000;
        model_memreg = '0;
        idle_inputs();

        #2;
        check("rst:pipe_en", pipe_en, 64'd1);
        check("rst:pcsrc", pcsrc_o, 64'd0);
        check("rst:req", dmem.mem_req, 64'd0);
        check("rst:err", mem_err, 64'd0);
        check("rst:memreg", memreg_o, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // ALU instructions stream through with no stall.
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aluout_i = 64'(i * 8);
            @(negedge clk);
            check("alu:pipe_en", pipe_en, 64'd1);
            check("alu:req", dmem.mem_req, 64'd0);
            tick();
        end
        idle_inputs();

        do_op("load40",  1'b1, 1'b0, 1'b0, 1'b0, 64'h40,  64'h0,    64'hDEAD_BEEF, 1);
        do_op("store80", 1'b0, 1'b1, 1'b0, 1'b0, 64'h80,  64'h1234, 64'hFFFF,      3);
        do_op("rdwr",    1'b1, 1'b1, 1'b0, 1'b0, 64'h100, 64'hCAFE, 64'h7777,      2);
        do_op("brload",  1'b1, 1'b0, 1'b1, 1'b1, 64'h48,  64'h0,    64'h0123_4567_89AB_CDEF, 2);
        do_op("ack_at_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 64'h200, 64'h0, 64'hA5A5, TIMEOUT);

        // Stray ack in IDLE alongside a taken branch.
        valid_i        = 1'b1;
        membranch_i    = 1'b1;
        zero_i         = 1'b1;
        branchpc_i     = 64'h0000_0000_0040_2000;
        dmem.mem_ack   = 1'b1;
        dmem.mem_rdata = 64'h5555;
        @(negedge clk);
        check("stray:pcsrc", pcsrc_o, 64'd1);
        check("stray:branchpc", branchpc_o, 64'h0000_0000_0040_2000);
        check("stray:pipe_en", pipe_en, 64'd1);
        tick();
        dmem.mem_ack = 1'b0;
        zero_i       = 1'b0;
        @(negedge clk);
        check("stray:memreg", memreg_o, model_memreg);
        check("stray:pcsrc_nz", pcsrc_o, 64'd0);
        tick();
        idle_inputs();

        // Load that is never acknowledged.
        valid_i   = 1'b1;
        memread_i = 1'b1;
        aluout_i  = 64'h400;
        for (int c = 0; c <= TIMEOUT; c++) begin
            @(negedge clk);
            check("tmo:err_pending", mem_err, 64'd0);
            check("tmo:pipe_en", pipe_en, 64'd0);
            if (c >= 1) check("tmo:req", dmem.mem_req, 64'd1);
            tick();
        end
        @(negedge clk);
        check("tmo:err", mem_err, 64'd1);
        check("tmo:err_pipe_en", pipe_en, 64'd0);
        check("tmo:err_req", dmem.mem_req, 64'd0);
        tick();
        dmem.mem_ack   = 1'b1;
        dmem.mem_rdata = 64'hBAD;
        tick();
        idle_inputs();
        @(negedge clk);
        check("tmo:spurious_memreg", memreg_o, model_memreg);
        check("tmo:sticky_err", mem_err, 64'd1);
        check("tmo:sticky_pipe_en", pipe_en, 64'd0);
        arst_n = 1'b0;
        model_memreg = '0;
        #1;
        check("tmo:rst_err", mem_err, 64'd0);
        check("tmo:rst_memreg", memreg_o, 64'd0);
        check("tmo:rst_pipe_en", pipe_en, 64'd1);
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        tick();

        // Reset pulsed in the second ACCESS cycle of a load.
        do_op("preload", 1'b1, 1'b0, 1'b0, 1'b0, 64'h60, 64'h0, 64'h55AA_0000, 1);
        valid_i   = 1'b1;
        memread_i = 1'b1;
        aluout_i  = 64'h300;
        @(negedge clk);
        check("midrst:idle_pipe_en", pipe_en, 64'd0);
        tick();
        @(negedge clk);
        check("midrst:req_a1", dmem.mem_req, 64'd1);
        tick();
        check("midrst:req_a2", dmem.mem_req, 64'd1);
        arst_n = 1'b0;
        model_memreg = '0;
        #1;
        check("midrst:req_drop", dmem.mem_req, 64'd0);
        check("midrst:memreg", memreg_o, 64'd0);
        check("midrst:err", mem_err, 64'd0);
        idle_inputs();
        #1;
        check("midrst:pipe_en", pipe_en, 64'd1);
        check("midrst:pcsrc", pcsrc_o, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        @(negedge clk);
        check("midrst:post_req", dmem.mem_req, 64'd0);
        check("midrst:post_pipe_en", pipe_en, 64'd1);
        tick();
        do_op("postload", 1'b1, 1'b0, 1'b0, 1'b0, 64'h500, 64'h0, 64'h1357_9BDF, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
